tmu2_hinterp: RTL



---
 rtl/tmu2_hinterp.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tmu2_hinterp.sv
// Horizontal span interpolator: one divided-difference record in, len points out with Bresenham-stepped texcoords.
// First point valid one cycle after accept, one point per cycle; outputs hold while pipe_ack_i is low.
module tmu2_hinterp (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  output logic               busy,
  input  logic               pipe_stb_i,
  output logic               pipe_ack_o,
  input  logic signed [11:0] x,
  input  logic signed [11:0] y,
  input  logic signed [17:0] tsx,
  input  logic signed [17:0] tsy,
  input  logic               diff_x_positive,
  input  logic               diff_y_positive,
  input  logic [16:0]        diff_x_q,
  input  logic [16:0]        diff_x_r,
  input  logic [16:0]        diff_y_q,
  input  logic [16:0]        diff_y_r,
  input  logic [10:0]        dst_squarew,
  output logic               pipe_stb_o,
  input  logic               pipe_ack_i,
  output logic signed [11:0] dx,
  output logic signed [11:0] dy,
  output logic signed [17:0] tx,
  output logic signed [17:0] ty
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic        accept, advance;
  logic [10:0] len, cnt;
  logic [10:0] err_x, err_y;
  logic [16:0] q_x, q_y, r_x, r_y;
  logic        pos_x, pos_y;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Handshake outputs depend on state alone, never on the incoming strobes.
  always_comb begin
    state_nxt  = state;
    pipe_ack_o = 1'b0;
    pipe_stb_o = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        pipe_ack_o = 1'b1;
        if (pipe_stb_i) begin
          accept = 1'b1;
          if (dst_squarew != 11'd0) state_nxt = RUN;
        end
      end
      RUN: begin
        pipe_stb_o = 1'b1;
        busy       = 1'b1;
        if (pipe_ack_i) begin
          if (cnt == len) state_nxt = IDLE;
          else            advance   = 1'b1;
        end
      end
    endcase
  end

  // Error accumulators stay below len, so one conditional subtract suffices.
  logic [17:0] len_ext, sum_x, sum_y, inc_x, inc_y;
  logic        wrap_x, wrap_y;
  logic [10:0] err_x_nxt, err_y_nxt;
  logic signed [17:0] tx_nxt, ty_nxt;

  always_comb begin
    len_ext   = {7'd0, len};
    sum_x     = {7'd0, err_x} + {1'b0, r_x};
    sum_y     = {7'd0, err_y} + {1'b0, r_y};
    wrap_x    = sum_x >= len_ext;
    wrap_y    = sum_y >= len_ext;
    inc_x     = {1'b0, q_x} + {17'd0, wrap_x};
    inc_y     = {1'b0, q_y} + {17'd0, wrap_y};
    err_x_nxt = wrap_x ? 11'(sum_x - len_ext) : sum_x[10:0];
    err_y_nxt = wrap_y ? 11'(sum_y - len_ext) : sum_y[10:0];
    tx_nxt    = pos_x ? tx + $signed(inc_x) : tx - $signed(inc_x);
    ty_nxt    = pos_y ? ty + $signed(inc_y) : ty - $signed(inc_y);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dx    <= '0;
      dy    <= '0;
      tx    <= '0;
      ty    <= '0;
      cnt   <= '0;
      len   <= '0;
      err_x <= '0;
      err_y <= '0;
      q_x   <= '0;
      q_y   <= '0;
      r_x   <= '0;
      r_y   <= '0;
      pos_x <= 1'b0;
      pos_y <= 1'b0;
    end else if (accept) begin
      dx    <= x;
      dy    <= y;
      tx    <= tsx;
      ty    <= tsy;
      cnt   <= 11'd1;
      len   <= dst_squarew;
      err_x <= '0;
      err_y <= '0;
      q_x   <= diff_x_q;
      q_y   <= diff_y_q;
      r_x   <= diff_x_r;
      r_y   <= diff_y_r;
      pos_x <= diff_x_positive;
      pos_y <= diff_y_positive;
    end else if (advance) begin
      cnt   <= cnt + 11'd1;
      dx    <= dx + 12'sd1;
      tx    <= tx_nxt;
      ty    <= ty_nxt;
      err_x <= err_x_nxt;
      err_y <= err_y_nxt;
    end
  end

endmodule
